// File: rtl/sha256_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha256_sync_pkg
// Description : Shared types and constants for the SHA-256 stream joiner.
// Revision    : 1.0 - initial release
// ============================================================================
package sha256_sync_pkg;

    // How per-channel last bits combine into the joined last
    typedef enum logic [0:0] {
        LAST_OR  = 1'b0,
        LAST_AND = 1'b1
    } last_mode_t;

    localparam int unsigned c_DEF_NUM_CH     = 2;
    localparam int unsigned c_DEF_CH_W       = 64;
    localparam int unsigned c_DEF_FIFO_DEPTH = 2;

    // Bit offset of channel ch inside a packed multi-channel bus
    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned ch_w);
        return ch * ch_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sha256_sync_fifo
// Description : Per-channel synchronous FIFO, wrap-bit pointers, head output.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_sync_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_AW:0]    wptr_q, wptr_d;
    logic [c_AW:0]    rptr_q, rptr_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[c_AW] != rptr_q[c_AW]) &&
                     (wptr_q[c_AW-1:0] == rptr_q[c_AW-1:0]);
    assign rdata_o = mem_q[rptr_q[c_AW-1:0]];

    // A full FIFO may still take a word when the head leaves in the same cycle
    assign w_do_push = push_i && (!full_o || pop_i);
    assign w_do_pop  = pop_i && !empty_o;

    // Pointer advance; the extra MSB wraps modulo 2*DEPTH
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (w_do_push) wptr_d = wptr_q + 1'b1;
        if (w_do_pop)  rptr_d = rptr_q + 1'b1;
    end

    // Pointer registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk) begin
        if (w_do_push && !rst) mem_q[wptr_q[c_AW-1:0]] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/sha256_stream_join.sv
`default_nettype none
// ============================================================================
// Module      : sha256_stream_join
// Description : Joins NUM_CH buffered valid/ready streams into one registered
//               output word with merged last and last-mismatch pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_stream_join
    import sha256_sync_pkg::*;
#(
    parameter int unsigned NUM_CH     = c_DEF_NUM_CH,
    parameter int unsigned CH_W       = c_DEF_CH_W,
    parameter int unsigned FIFO_DEPTH = c_DEF_FIFO_DEPTH,
    parameter last_mode_t  LAST_MODE  = LAST_OR
) (
    input  logic                   clk,
    input  logic                   sync_rst,
    input  logic                   en,
    input  logic [NUM_CH*CH_W-1:0] in_data,
    input  logic [NUM_CH-1:0]      in_last,
    input  logic [NUM_CH-1:0]      in_valid,
    output logic [NUM_CH-1:0]      in_ready,
    output logic [NUM_CH*CH_W-1:0] out_data,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   last_err
);
    logic [NUM_CH-1:0]      w_full;
    logic [NUM_CH-1:0]      w_empty;
    logic [NUM_CH-1:0]      w_push;
    logic [NUM_CH-1:0]      w_head_last;
    logic [NUM_CH*CH_W-1:0] w_head_data;
    logic                   w_can_load;
    logic                   w_join;
    logic                   w_merged_last;
    logic                   w_last_mismatch;

    logic [NUM_CH*CH_W-1:0] out_data_q, out_data_d;
    logic                   out_last_q, out_last_d;
    logic                   out_valid_q, out_valid_d;
    logic                   last_err_q, last_err_d;

    // Ready depends only on FIFO state and enable, never on valid
    assign in_ready = (en && !sync_rst) ? ~w_full : '0;
    assign w_push   = in_valid & in_ready;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CH_W:0] w_head;

            sha256_sync_fifo #(
                .WIDTH (CH_W + 1),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst     (sync_rst),
                .push_i  (w_push[gi]),
                .pop_i   (w_join),
                .wdata_i ({in_last[gi], in_data[ch_lsb(gi, CH_W) +: CH_W]}),
                .rdata_o (w_head),
                .full_o  (w_full[gi]),
                .empty_o (w_empty[gi])
            );

            assign w_head_data[ch_lsb(gi, CH_W) +: CH_W] = w_head[CH_W-1:0];
            assign w_head_last[gi]                       = w_head[CH_W];
        end
    endgenerate

    assign w_can_load      = !out_valid_q || out_ready;
    assign w_join          = en && (w_empty == '0) && w_can_load;
    assign w_merged_last   = (LAST_MODE == LAST_AND) ? (&w_head_last) : (|w_head_last);
    assign w_last_mismatch = (|w_head_last) && !(&w_head_last);

    // Output register next state: load on join, drop valid on a bare handshake
    always_comb begin
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        last_err_d  = w_join && w_last_mismatch;
        if (w_join) begin
            out_data_d  = w_head_data;
            out_last_d  = w_merged_last;
            out_valid_d = 1'b1;
        end else if (en && out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register; reset clears everything including the error pulse
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            last_err_q  <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            last_err_q  <= last_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign last_err  = last_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256_stream_join.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_stream_join
// Description : Scoreboard bench, 3 channels x 8 bits, OR and AND last modes
//               driven in parallel from the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_stream_join;
    import sha256_sync_pkg::*;

    typedef struct {
        logic [23:0] d;
        logic        lor;
        logic        land;
    } exp_t;

    logic        clk;
    logic        sync_rst;
    logic        en;
    logic        out_ready;
    logic [23:0] in_data;
    logic [2:0]  in_last;
    logic [2:0]  in_valid;

    logic [2:0]  a_in_ready, b_in_ready;
    logic [23:0] a_out_data, b_out_data;
    logic        a_out_last, b_out_last;
    logic        a_out_valid, b_out_valid;
    logic        a_last_err, b_last_err;

    int          checks = 0;
    int          errors = 0;

    exp_t        exp_q[$];
    logic [8:0]  chq[3][$];
    int          gap[3];
    int          gcnt[3];
    int          acc_cnt[3];
    logic [2:0]  acc;

    sha256_stream_join #(
        .NUM_CH(3), .CH_W(8), .FIFO_DEPTH(2), .LAST_MODE(LAST_OR)
    ) u_dut_or (
        .clk(clk), .sync_rst(sync_rst), .en(en),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_last(a_out_last), .out_valid(a_out_valid),
        .out_ready(out_ready), .last_err(a_last_err)
    );

    sha256_stream_join #(
        .NUM_CH(3), .CH_W(8), .FIFO_DEPTH(2), .LAST_MODE(LAST_AND)
    ) u_dut_and (
        .clk(clk), .sync_rst(sync_rst), .en(en),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_last(b_out_last), .out_valid(b_out_valid),
        .out_ready(out_ready), .last_err(b_last_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue one word per channel; optionally register the hand-computed joined word
    task automatic send(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                        input logic [2:0] lasts, input logic [23:0] exp_d,
                        input logic exp_or, input logic exp_and, input bit keep);
        chq[0].push_back({lasts[0], d0});
        chq[1].push_back({lasts[1], d1});
        chq[2].push_back({lasts[2], d2});
        if (keep) exp_q.push_back('{d: exp_d, lor: exp_or, land: exp_and});
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || chq[0].size() != 0 || chq[1].size() != 0 ||
                chq[2].size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_within_budget", 64'(n < 200), 64'd1);
        step();
        step();
    endtask

    // Handshake capture for the producers
    always @(negedge clk) acc = in_valid & a_in_ready;

    // Producers: present queue heads, optional idle gap after each accept
    initial begin
        in_valid = '0;
        in_data  = '0;
        in_last  = '0;
        for (int c = 0; c < 3; c++) begin
            gcnt[c]    = 0;
            acc_cnt[c] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < 3; c++) begin
                if (acc[c]) begin
                    void'(chq[c].pop_front());
                    acc_cnt[c]++;
                    gcnt[c] = gap[c];
                end else if (gcnt[c] > 0) begin
                    gcnt[c]--;
                end
                if (chq[c].size() != 0 && gcnt[c] == 0) begin
                    in_valid[c]         = 1'b1;
                    in_data[c*8 +: 8]   = chq[c][0][7:0];
                    in_last[c]          = chq[c][0][8];
                end else begin
                    in_valid[c] = 1'b0;
                end
            end
        end
    end

    // Monitor: every accepted output word is compared against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!sync_rst && en && a_out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 64'(a_out_data), 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                chk("out_data_or",   64'(a_out_data), 64'(e.d));
                chk("out_last_or",   64'(a_out_last), 64'(e.lor));
                chk("out_data_and",  64'(b_out_data), 64'(e.d));
                chk("out_last_and",  64'(b_out_last), 64'(e.land));
                chk("out_valid_and", 64'(b_out_valid), 64'd1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int base[3];
        gap[0] = 0; gap[1] = 0; gap[2] = 0;
        sync_rst  = 1'b1;
        en        = 1'b0;
        out_ready = 1'b0;
        step();
        step();

        // Reset values
        @(negedge clk);
        chk("rst_in_ready_or",  64'(a_in_ready), 64'd0);
        chk("rst_in_ready_and", 64'(b_in_ready), 64'd0);
        chk("rst_out_valid",    64'(a_out_valid), 64'd0);
        chk("rst_out_data",     64'(a_out_data), 64'd0);
        chk("rst_out_last",     64'(a_out_last), 64'd0);
        chk("rst_last_err",     64'(a_last_err), 64'd0);
        step();
        sync_rst  = 1'b0;
        en        = 1'b1;
        out_ready = 1'b1;

        // Single join with two-edge latency
        send(8'h11, 8'h22, 8'h33, 3'b000, 24'h332211, 1'b0, 1'b0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if ((in_valid & a_in_ready) == 3'b111) seen = 1'b1;
        end
        chk("t1_accept", 64'(seen), 64'd1);
        @(negedge clk);
        chk("t1_valid_after_E", 64'(a_out_valid), 64'd0);
        @(negedge clk);
        chk("t1_valid_after_E1", 64'(a_out_valid), 64'd1);
        wait_idle();

        // Skewed arrival: channel 1 offers one word every third cycle
        gap[1] = 2;
        send(8'hA0, 8'hB0, 8'hC0, 3'b000, 24'hC0B0A0, 1'b0, 1'b0, 1'b1);
        send(8'hA1, 8'hB1, 8'hC1, 3'b000, 24'hC1B1A1, 1'b0, 1'b0, 1'b1);
        send(8'hA2, 8'hB2, 8'hC2, 3'b000, 24'hC2B2A2, 1'b0, 1'b0, 1'b1);
        send(8'hA3, 8'hB3, 8'hC3, 3'b000, 24'hC3B3A3, 1'b0, 1'b0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (!a_in_ready[0] && in_valid[0]) seen = 1'b1;
        end
        chk("t2_ch0_ready_drop", 64'(seen), 64'd1);
        wait_idle();
        gap[1] = 0;

        // Backpressure: FIFO_DEPTH words per channel plus one in the output register
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) base[c] = acc_cnt[c];
        send(8'h30, 8'h40, 8'h50, 3'b000, 24'h504030, 1'b0, 1'b0, 1'b1);
        send(8'h31, 8'h41, 8'h51, 3'b000, 24'h514131, 1'b0, 1'b0, 1'b1);
        send(8'h32, 8'h42, 8'h52, 3'b000, 24'h524232, 1'b0, 1'b0, 1'b1);
        send(8'h33, 8'h43, 8'h53, 3'b000, 24'h534333, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        for (int c = 0; c < 3; c++) chk("t3_accepted", 64'(acc_cnt[c] - base[c]), 64'd3);
        chk("t3_in_ready_low", 64'(a_in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_held_data",  64'(a_out_data), 64'h504030);
            chk("t3_held_valid", 64'(a_out_valid), 64'd1);
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_ready_before_release_edge", 64'(a_in_ready), 64'd0);
        @(negedge clk);
        chk("t3_ready_after_release_edge", 64'(a_in_ready), 64'h7);
        chk("t3_drain_valid_1", 64'(a_out_valid), 64'd1);
        @(negedge clk);
        chk("t3_drain_valid_2", 64'(a_out_valid), 64'd1);
        wait_idle();

        // Last mismatch: ch0 last=1, others 0
        send(8'h01, 8'h02, 8'h03, 3'b001, 24'h030201, 1'b1, 1'b0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (a_out_valid) seen = 1'b1;
        end
        chk("t4_out_seen", 64'(seen), 64'd1);
        chk("t4_err_or",  64'(a_last_err), 64'd1);
        chk("t4_err_and", 64'(b_last_err), 64'd1);
        @(negedge clk);
        chk("t4_err_pulse_or",  64'(a_last_err), 64'd0);
        chk("t4_err_pulse_and", 64'(b_last_err), 64'd0);
        wait_idle();
        send(8'h04, 8'h05, 8'h06, 3'b111, 24'h060504, 1'b1, 1'b1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (a_out_valid) seen = 1'b1;
        end
        chk("t4_match_no_err", 64'(a_last_err), 64'd0);
        wait_idle();

        // Enable low while a word is held
        out_ready = 1'b0;
        send(8'h41, 8'h42, 8'h43, 3'b000, 24'h434241, 1'b0, 1'b0, 1'b1);
        send(8'h44, 8'h45, 8'h46, 3'b000, 24'h464544, 1'b0, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        step();
        en        = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_valid_held", 64'(a_out_valid), 64'd1);
            chk("t5_data_held",  64'(a_out_data), 64'h434241);
            chk("t5_in_ready",   64'(a_in_ready), 64'd0);
            chk("t5_last_err",   64'(a_last_err), 64'd0);
        end
        step();
        en = 1'b1;
        wait_idle();

        // Reset with words buffered and output valid
        out_ready = 1'b0;
        send(8'h61, 8'h62, 8'h63, 3'b000, 24'h0, 1'b0, 1'b0, 1'b0);
        send(8'h71, 8'h72, 8'h73, 3'b000, 24'h0, 1'b0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        chk("t6_pre_valid", 64'(a_out_valid), 64'd1);
        step();
        sync_rst = 1'b1;
        @(negedge clk);
        chk("t6_in_ready_in_rst", 64'(a_in_ready), 64'd0);
        @(negedge clk);
        chk("t6_out_valid", 64'(a_out_valid), 64'd0);
        chk("t6_out_data",  64'(a_out_data), 64'd0);
        chk("t6_out_last",  64'(a_out_last), 64'd0);
        chk("t6_last_err",  64'(a_last_err), 64'd0);
        step();
        sync_rst  = 1'b0;
        out_ready = 1'b1;
        send(8'h81, 8'h82, 8'h83, 3'b000, 24'h838281, 1'b0, 1'b0, 1'b1);
        wait_idle();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
